// File: rtl/mem_split_ctrl_pkg.sv
// Shared encodings for the memory-stage split sequencer: access sizes, FSM states
// and the predicate that decides whether an access needs two beats.
package mem_split_ctrl_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT0 = 2'd1,
        ST_SPLIT = 2'd2
    } state_e;

    // A word crosses a word boundary at any nonzero offset; a half only at offset 3.
    function automatic logic is_split(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_WORD) && (off != 2'd0)) ||
               ((size == SZ_HALF) && (off == 2'd3));
    endfunction

endpackage

// File: rtl/mem_split_ctrl_lane_gen.sv
// Combinational lane generator: byte enables and lane-shifted store data for the
// first or second beat of an access, plus the split indication.
module mem_lane_gen
    import mem_split_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        beat_sel_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        split_o
);

    logic [4:0] sh_amt;
    logic [5:0] sh_amt_hi;

    assign split_o   = is_split(size_i, off_i);
    assign sh_amt    = {off_i, 3'b000};
    assign sh_amt_hi = 6'd32 - {1'b0, sh_amt};

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        be_o = 4'b0000;
        case (size_i)
            SZ_WORD: begin
                if (!split_o)        be_o = 4'b1111;
                else if (beat_sel_i) be_o = (4'b0001 << off_i) - 4'b0001;
                else                 be_o = 4'b1111 << off_i;
            end
            SZ_HALF: begin
                if (!split_o)        be_o = 4'b0011 << off_i;
                else if (beat_sel_i) be_o = 4'b0001;
                else                 be_o = 4'b1000;
            end
            SZ_BYTE: be_o = 4'b0001 << off_i;
            default: be_o = 4'b0000;
        endcase
    end

    // Second beat carries the bytes that spilled past lane 3; offset 0 shifts everything out.
    assign wdata_o = beat_sel_i ? (wdata_i >> sh_amt_hi) : (wdata_i << sh_amt);

endmodule

// File: rtl/mem_split_ctrl.sv
// Memory-stage sequencer: issues one or two word-aligned beats per load/store,
// stalls upstream while a split or a memory wait is outstanding.
module mem_split_ctrl
    import mem_split_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    input  logic        mem_ready,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        stall_out,
    output logic        wb_misaligned
);

    state_e      state_q, state_d;
    logic        lat_load_q, lat_store_q;
    logic [1:0]  lat_size_q;
    logic [31:0] lat_addr_q, lat_wdata_q;

    logic        use_lat, beat_sel, live_access, capture;
    logic        cur_store;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata, base_addr, beat_addr;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        lane_split;
    logic        beat_en, stall, wb;

    // Outside IDLE the live request may already have moved on; work from the latched copy.
    assign use_lat   = (state_q != ST_IDLE);
    assign beat_sel  = (state_q == ST_SPLIT);
    assign cur_store = use_lat ? lat_store_q : req_is_store;
    assign cur_size  = use_lat ? lat_size_q  : req_size;
    assign cur_addr  = use_lat ? lat_addr_q  : req_addr;
    assign cur_wdata = use_lat ? lat_wdata_q : req_wdata;

    assign live_access = req_valid && (req_is_load || req_is_store) && (req_size != SZ_RSVD);

    mem_lane_gen u_lane_gen (
        .size_i     (cur_size),
        .off_i      (cur_addr[1:0]),
        .beat_sel_i (beat_sel),
        .wdata_i    (cur_wdata),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .split_o    (lane_split)
    );

    assign base_addr = {cur_addr[31:2], 2'b00};
    assign beat_addr = beat_sel ? base_addr + 32'd4 : base_addr;

    always_comb begin
        state_d = state_q;
        beat_en = 1'b0;
        stall   = 1'b0;
        wb      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (live_access && !flush) begin
                    beat_en = 1'b1;
                    if (!mem_ready) begin
                        state_d = ST_WAIT0;
                        stall   = 1'b1;
                    end else if (lane_split) begin
                        state_d = ST_SPLIT;
                        stall   = 1'b1;
                    end
                end
            end
            ST_WAIT0: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_en = 1'b1;
                    if (mem_ready) begin
                        if (lane_split) begin
                            state_d = ST_SPLIT;
                        end else begin
                            state_d = ST_IDLE;
                            stall   = 1'b0;
                        end
                    end
                end
            end
            ST_SPLIT: begin
                // A split store must finish both halves; only a split load can be killed here.
                if (flush && lat_load_q) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_en = 1'b1;
                    stall   = 1'b1;
                    if (mem_ready) begin
                        state_d = ST_IDLE;
                        stall   = 1'b0;
                        wb      = lat_load_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            state_d = ST_IDLE;
            beat_en = 1'b0;
            stall   = 1'b0;
            wb      = 1'b0;
        end
    end

    assign capture = (state_q == ST_IDLE) && (state_d != ST_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_load_q  <= 1'b0;
            lat_store_q <= 1'b0;
            lat_size_q  <= SZ_WORD;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                lat_load_q  <= req_is_load;
                lat_store_q <= req_is_store;
                lat_size_q  <= req_size;
                lat_addr_q  <= req_addr;
                lat_wdata_q <= req_wdata;
            end
        end
    end

    assign mem_en        = beat_en;
    assign mem_addr      = beat_en ? beat_addr  : 32'd0;
    assign mem_be        = beat_en ? lane_be    : 4'b0000;
    assign mem_we        = beat_en & cur_store;
    assign mem_wdata     = beat_en ? lane_wdata : 32'd0;
    assign stall_out     = stall;
    assign wb_misaligned = wb;

endmodule
